instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, shall set the PC value loaded at reset.
REQ-002 Port clk, input, 1, shall be the single clock; all state updates occur on its rising edge.
REQ-003 Port reset, input, 1, shall be the asynchronous, active-low reset.
REQ-004 Port fetch_en, input, 1, shall permit issue of the next fetch when sampled high in IDLE.
REQ-005 Port redirect, input, 1, shall request a PC change (branch/jump) this cycle.
REQ-006 Port redirect_pc, input, 32, shall carry the redirect target.
REQ-007 Port mem_req, output, 1, shall be the memory read request.
REQ-008 Port mem_addr, output, 32, shall be the word-aligned read address.
REQ-009 Port mem_ack, input, 1, shall indicate mem_rdata is valid this cycle.
REQ-010 Port mem_rdata, input, 32, shall be the returned instruction word.
REQ-011 Port write_ir, output, 1, shall be a one-cycle pulse loading the instruction register.
REQ-012 Port instruction, output, 32, shall be the registered fetched word, valid while write_ir=1.
REQ-013 Port pc_out, output, 32, shall be the address of the word on instruction.
REQ-014 Port fetch_fault, output, 1, shall flag a misaligned redirect target (only with macro).
REQ-015 Port busy, output, 1, shall be high whenever state is not IDLE.

Function
REQ-016 FSM states shall be IDLE, WAIT, DROP, FAULT.
REQ-017 mem_req shall equal (state==WAIT or state==DROP); mem_addr shall equal the PC register with bits [1:0]=00 and shall hold stable while mem_req=1.
REQ-018 IDLE: redirect=1 -> PC<=redirect_pc, stay IDLE (redirect wins over fetch_en); else fetch_en=1 -> WAIT.
REQ-019 WAIT, mem_ack=1, redirect=0: instruction<=mem_rdata, pc_out<=PC, PC<=PC+4 (mod 2^32 wrap), write_ir=1 next cycle, -> IDLE.
REQ-020 WAIT, redirect=1, mem_ack=0: PC<=redirect_pc, -> DROP; request stays asserted (not withdrawable).
REQ-021 WAIT, redirect=1 and mem_ack=1 same cycle: data discarded, no write_ir, PC<=redirect_pc, -> IDLE.
REQ-022 DROP: redirect=1 updates PC, stays DROP; mem_ack=1 discards data, -> IDLE; no write_ir ever results from DROP.
REQ-023 Minimum latency: fetch_en cycle N, mem_req N+1, ack N+1, write_ir N+2; one outstanding request max.
REQ-024 mem_ack in IDLE or FAULT shall be ignored.
REQ-025 write_ir shall be high for exactly one cycle per accepted word and low otherwise.

Reset
REQ-026 reset low shall immediately force state=IDLE, PC=RESET_PC, mem_req=0, write_ir=0, instruction=0, pc_out=0, fetch_fault=0, busy=0.
REQ-027 Reset mid-transaction shall abandon the request; a later stale mem_ack shall be ignored per REQ-024.

Configuration
REQ-028 Macro IFETCH_MISALIGN_TRAP_EN defined: redirect with redirect_pc[1:0]!=0 in any state shall -> FAULT, fetch_fault=1, no new requests, fetch_en ignored, pending data discarded; only an aligned redirect leaves FAULT (-> IDLE, PC loaded, fetch_fault=0), except in-flight request completes via DROP first.
REQ-029 Macro undefined: FAULT unreachable, fetch_fault tied 0, redirect_pc[1:0] ignored (PC bits [1:0] forced 00).

Verification
REQ-030 Reset release, RESET_PC=0, fetch_en=1, mem_ack same cycle as mem_req, mem_rdata=32'h00500093 -> write_ir pulse at cycle N+2, instruction=32'h00500093, pc_out=0, next mem_addr=4.
REQ-031 Memory with 3-cycle ack delay -> mem_req held high, mem_addr stable 3 cycles, single write_ir pulse.
REQ-032 redirect_pc=32'h100 during WAIT with ack 2 cycles later -> DROP, no write_ir, next request mem_addr=32'h100.
REQ-033 redirect_pc=32'h200 coincident with mem_ack -> no write_ir, IDLE, next mem_addr=32'h200; PC=32'hFFFFFFFC fetch -> next mem_addr=0.
REQ-034 Macro defined, redirect_pc=32'h102 -> fetch_fault=1, mem_req=0 despite fetch_en=1; redirect_pc=32'h104 -> fetch_fault=0, next mem_addr=32'h104; macro undefined same stimulus -> mem_addr=32'h100.
REQ-035 reset low during WAIT, stale mem_ack after release -> state IDLE, no write_ir, mem_addr=RESET_PC on next fetch.

Source files
------------

// File: rtl/instr_fetch.sv
// instr_fetch: single-outstanding instruction fetch unit with branch/jump redirect.
// Optional feature: define IFETCH_MISALIGN_TRAP_EN to trap misaligned redirect
// targets in a FAULT state (fetch_fault=1) instead of silently aligning them.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_en,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        write_ir,
  output logic [31:0] instruction,
  output logic [31:0] pc_out,
  output logic        fetch_fault,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, WAIT, DROP, FAULT} state_t;

  localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

  state_t      state;
  state_t      next_state;
  logic [31:0] pc;
  logic [31:0] req_addr;
  logic        aligned;
  logic        redirect_ok;
  logic        redirect_bad;
  logic        accept;
  logic        fault_q;

`ifdef IFETCH_MISALIGN_TRAP_EN
  assign aligned = (redirect_pc[1:0] == 2'b00);
`else
  assign aligned = 1'b1;
`endif

  assign redirect_ok  = redirect & aligned;
  assign redirect_bad = redirect & ~aligned;
  // A word is delivered only when the ack lands in WAIT with no competing redirect.
  assign accept       = (state == WAIT) & mem_ack & ~redirect;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic; an issued request always runs to its ack, via DROP if redirected.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (redirect_bad)     next_state = FAULT;
        else if (redirect_ok) next_state = IDLE;
        else if (fetch_en)    next_state = WAIT;
      end
      WAIT: begin
        if (redirect) begin
          if (!mem_ack)         next_state = DROP;
          else if (redirect_bad) next_state = FAULT;
          else                  next_state = IDLE;
        end else if (mem_ack) begin
          next_state = IDLE;
        end
      end
      DROP: begin
        if (mem_ack) begin
          if (redirect_bad)     next_state = FAULT;
          else if (redirect_ok) next_state = IDLE;
          else if (fault_q)     next_state = FAULT;
          else                  next_state = IDLE;
        end
      end
      FAULT: begin
        if (redirect_ok) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Output decode; the address is frozen in req_addr while a request is outstanding.
  always_comb begin
    mem_req  = (state == WAIT) || (state == DROP);
    busy     = (state != IDLE);
    mem_addr = mem_req ? req_addr : pc;
  end

  // PC, request address and instruction register datapath.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc          <= RESET_PC & WORD_MASK;
      req_addr    <= RESET_PC & WORD_MASK;
      instruction <= 32'h0;
      pc_out      <= 32'h0;
      write_ir    <= 1'b0;
    end else begin
      write_ir <= accept;
      if (state == IDLE) req_addr <= pc;
      if (redirect_ok) begin
        pc <= redirect_pc & WORD_MASK;
      end else if (accept) begin
        pc <= pc + 32'd4;
      end
      if (accept) begin
        instruction <= mem_rdata;
        pc_out      <= req_addr;
      end
    end
  end

`ifdef IFETCH_MISALIGN_TRAP_EN
  // Fault flag: set by any misaligned redirect, cleared by an aligned one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)            fault_q <= 1'b0;
    else if (redirect_bad) fault_q <= 1'b1;
    else if (redirect_ok)  fault_q <= 1'b0;
  end
`else
  assign fault_q = 1'b0;
`endif

  assign fetch_fault = fault_q;

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed self-checking bench for instr_fetch.
// Inputs change just after the falling edge; outputs are checked at the falling edge.
module tb_instr_fetch;

  logic        clk;
  logic        reset;
  logic        fetch_en;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        write_ir;
  logic [31:0] instruction;
  logic [31:0] pc_out;
  logic        fetch_fault;
  logic        busy;

  int checks = 0;
  int errors = 0;

  instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .fetch_en(fetch_en), .redirect(redirect),
    .redirect_pc(redirect_pc), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .write_ir(write_ir),
    .instruction(instruction), .pc_out(pc_out), .fetch_fault(fetch_fault),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0; fetch_en = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    mem_ack = 1'b0; mem_rdata = 32'h0;
    tick(); tick();
    checks++; if ({mem_req, write_ir, fetch_fault, busy} !== 4'b0000) begin errors++;
      $display("[TB] FAIL reset_flags got %b want 0000", {mem_req, write_ir, fetch_fault, busy}); end
    checks++; if (instruction !== 32'h0 || pc_out !== 32'h0) begin errors++;
      $display("[TB] FAIL reset_regs got ir=%h pc_out=%h want 0/0", instruction, pc_out); end
    checks++; if (mem_addr !== 32'h0) begin errors++;
      $display("[TB] FAIL reset_addr got %h want 00000000", mem_addr); end
    reset = 1'b1;
  endtask

  task automatic test_single_fetch();
    fetch_en = 1'b1;
    tick();
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h0 || write_ir !== 1'b0) begin errors++;
      $display("[TB] FAIL first_req got req=%b addr=%h wir=%b want 1/0/0", mem_req, mem_addr, write_ir); end
    fetch_en = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h0050_0093;
    tick();
    mem_ack = 1'b0;
    checks++; if (write_ir !== 1'b1 || instruction !== 32'h0050_0093 || pc_out !== 32'h0) begin errors++;
      $display("[TB] FAIL first_word got wir=%b ir=%h pc=%h want 1/00500093/0", write_ir, instruction, pc_out); end
    checks++; if (busy !== 1'b0 || mem_req !== 1'b0) begin errors++;
      $display("[TB] FAIL first_idle got busy=%b req=%b want 0/0", busy, mem_req); end
    tick();
    checks++; if (write_ir !== 1'b0) begin errors++;
      $display("[TB] FAIL first_pulse_len got %b want 0", write_ir); end
  endtask

  task automatic test_slow_memory();
    int pulses = 0;
    fetch_en = 1'b1;
    tick();
    fetch_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h4) begin errors++;
        $display("[TB] FAIL slow_hold[%0d] got req=%b addr=%h want 1/00000004", i, mem_req, mem_addr); end
      if (write_ir === 1'b1) pulses++;
      if (i == 2) begin mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF; end
      tick();
    end
    mem_ack = 1'b0;
    checks++; if (write_ir !== 1'b1 || instruction !== 32'hDEAD_BEEF || pc_out !== 32'h4) begin errors++;
      $display("[TB] FAIL slow_word got wir=%b ir=%h pc=%h want 1/deadbeef/4", write_ir, instruction, pc_out); end
    if (write_ir === 1'b1) pulses++;
    tick();
    if (write_ir === 1'b1) pulses++;
    checks++; if (pulses != 1) begin errors++;
      $display("[TB] FAIL slow_pulses got %0d want 1", pulses); end
  endtask

  task automatic test_redirect_drop();
    fetch_en = 1'b1;
    tick();
    fetch_en = 1'b0; redirect = 1'b1; redirect_pc = 32'h100;
    tick();
    redirect = 1'b0;
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h8 || busy !== 1'b1) begin errors++;
      $display("[TB] FAIL drop_hold got req=%b addr=%h busy=%b want 1/00000008/1", mem_req, mem_addr, busy); end
    tick();
    mem_ack = 1'b1; mem_rdata = 32'h1111_1111;
    checks++; if (write_ir !== 1'b0 || mem_req !== 1'b1) begin errors++;
      $display("[TB] FAIL drop_wait got wir=%b req=%b want 0/1", write_ir, mem_req); end
    tick();
    mem_ack = 1'b0;
    checks++; if (write_ir !== 1'b0 || busy !== 1'b0 || instruction !== 32'hDEAD_BEEF) begin errors++;
      $display("[TB] FAIL drop_discard got wir=%b busy=%b ir=%h want 0/0/deadbeef", write_ir, busy, instruction); end
    fetch_en = 1'b1;
    tick();
    fetch_en = 1'b0;
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h100) begin errors++;
      $display("[TB] FAIL drop_target got req=%b addr=%h want 1/00000100", mem_req, mem_addr); end
    mem_ack = 1'b1; mem_rdata = 32'h2222_2222;
    tick();
    mem_ack = 1'b0;
    checks++; if (write_ir !== 1'b1 || pc_out !== 32'h100) begin errors++;
      $display("[TB] FAIL drop_fetch got wir=%b pc=%h want 1/00000100", write_ir, pc_out); end
  endtask

  task automatic test_redirect_with_ack();
    fetch_en = 1'b1;
    tick();
    fetch_en = 1'b0; redirect = 1'b1; redirect_pc = 32'h200; mem_ack = 1'b1; mem_rdata = 32'h3333_3333;
    tick();
    redirect = 1'b0; mem_ack = 1'b0;
    checks++; if (write_ir !== 1'b0 || busy !== 1'b0 || instruction !== 32'h2222_2222) begin errors++;
      $display("[TB] FAIL coinc_discard got wir=%b busy=%b ir=%h want 0/0/22222222", write_ir, busy, instruction); end
    fetch_en = 1'b1;
    tick();
    fetch_en = 1'b0;
    checks++; if (mem_addr !== 32'h200) begin errors++;
      $display("[TB] FAIL coinc_target got %h want 00000200", mem_addr); end
    mem_ack = 1'b1; mem_rdata = 32'h4444_4444;
    tick();
    mem_ack = 1'b0;
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC; fetch_en = 1'b1;
    tick();
    redirect = 1'b0;
    checks++; if (busy !== 1'b0 || mem_req !== 1'b0) begin errors++;
      $display("[TB] FAIL redirect_wins got busy=%b req=%b want 0/0", busy, mem_req); end
    tick();
    fetch_en = 1'b0;
    checks++; if (mem_addr !== 32'hFFFF_FFFC) begin errors++;
      $display("[TB] FAIL top_addr got %h want fffffffc", mem_addr); end
    mem_ack = 1'b1; mem_rdata = 32'h5555_5555;
    tick();
    mem_ack = 1'b0;
    checks++; if (write_ir !== 1'b1 || pc_out !== 32'hFFFF_FFFC) begin errors++;
      $display("[TB] FAIL top_word got wir=%b pc=%h want 1/fffffffc", write_ir, pc_out); end
    fetch_en = 1'b1;
    tick();
    fetch_en = 1'b0;
    checks++; if (mem_addr !== 32'h0) begin errors++;
      $display("[TB] FAIL wrap_addr got %h want 00000000", mem_addr); end
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
  endtask

  task automatic test_misalign();
    redirect = 1'b1; redirect_pc = 32'h102;
    tick();
    redirect = 1'b0; fetch_en = 1'b1;
`ifdef IFETCH_MISALIGN_TRAP_EN
    checks++; if (fetch_fault !== 1'b1 || busy !== 1'b1) begin errors++;
      $display("[TB] FAIL trap_enter got fault=%b busy=%b want 1/1", fetch_fault, busy); end
    tick();
    mem_ack = 1'b1;
    checks++; if (mem_req !== 1'b0 || fetch_fault !== 1'b1) begin errors++;
      $display("[TB] FAIL trap_hold got req=%b fault=%b want 0/1", mem_req, fetch_fault); end
    redirect = 1'b1; redirect_pc = 32'h104; fetch_en = 1'b0;
    tick();
    redirect = 1'b0; mem_ack = 1'b0;
    checks++; if (fetch_fault !== 1'b0 || busy !== 1'b0 || write_ir !== 1'b0) begin errors++;
      $display("[TB] FAIL trap_exit got fault=%b busy=%b wir=%b want 0/0/0", fetch_fault, busy, write_ir); end
    fetch_en = 1'b1;
    tick();
    fetch_en = 1'b0;
    checks++; if (mem_addr !== 32'h104) begin errors++;
      $display("[TB] FAIL trap_target got %h want 00000104", mem_addr); end
`else
    checks++; if (fetch_fault !== 1'b0 || busy !== 1'b0) begin errors++;
      $display("[TB] FAIL noalign_fault got fault=%b busy=%b want 0/0", fetch_fault, busy); end
    tick();
    fetch_en = 1'b0;
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h100) begin errors++;
      $display("[TB] FAIL noalign_addr got req=%b addr=%h want 1/00000100", mem_req, mem_addr); end
`endif
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    fetch_en = 1'b1;
    tick();
    fetch_en = 1'b0;
    reset = 1'b0;
    #1;
    checks++; if ({mem_req, write_ir, busy, fetch_fault} !== 4'b0000 || instruction !== 32'h0 || pc_out !== 32'h0) begin errors++;
      $display("[TB] FAIL async_reset got flags=%b ir=%h pc=%h want 0000/0/0", {mem_req, write_ir, busy, fetch_fault}, instruction, pc_out); end
    tick();
    reset = 1'b1; mem_ack = 1'b1; mem_rdata = 32'h6666_6666;
    tick();
    mem_ack = 1'b0;
    checks++; if (write_ir !== 1'b0 || busy !== 1'b0 || instruction !== 32'h0) begin errors++;
      $display("[TB] FAIL stale_ack got wir=%b busy=%b ir=%h want 0/0/0", write_ir, busy, instruction); end
    fetch_en = 1'b1;
    tick();
    fetch_en = 1'b0;
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin errors++;
      $display("[TB] FAIL post_reset_addr got req=%b addr=%h want 1/00000000", mem_req, mem_addr); end
    mem_ack = 1'b1; mem_rdata = 32'h7777_7777;
    tick();
    mem_ack = 1'b0;
    checks++; if (write_ir !== 1'b1 || instruction !== 32'h7777_7777 || pc_out !== 32'h0) begin errors++;
      $display("[TB] FAIL post_reset_word got wir=%b ir=%h pc=%h want 1/77777777/0", write_ir, instruction, pc_out); end
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_slow_memory();
    test_redirect_drop();
    test_redirect_with_ack();
    test_misalign();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
